mac_accum_drain: RTL and testbench
==================================

MAC_ACCUM_DRAIN -- requirements
Module: mac_accum_drain

Interface
REQ-001: Parameter ACC_W, default 32, sets the accumulator and result width in bits (minimum 18).
REQ-002: Parameter LEN_W, default 8, sets the width of the vector-length field.
REQ-003: Port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004: Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005: Port cfg_len, input, LEN_W bits: number of product beats per dot product; value 0 is treated as 1.
REQ-006: Port clear, input, 1 bit: synchronous abort of the vector in progress.
REQ-007: Port in_valid, input, 1 bit: product beat present, driven by the multiplier out_valid; no backpressure.
REQ-008: Port in_sum, input, 18 bits: unsigned product, driven by the multiplier out_sum.
REQ-009: Port out_valid, output, 1 bit: a result is available at the FIFO head.
REQ-010: Port out_ready, input, 1 bit: consumer accepts the head result.
REQ-011: Port out_acc, output, ACC_W bits: head result value.
REQ-012: Port out_drop, output, 1 bit: sticky flag, set when a result was lost.

Function
REQ-013: Datapath consists of a beat counter, a length register, an ACC_W accumulator and a 2-entry result FIFO.
REQ-014: Vector FSM has two states, IDLE (cnt=0, acc=0) and ACCUM.
REQ-015: In IDLE, a beat with in_valid=1 latches cfg_len into the length register and moves the FSM to ACCUM; if the length is 1, the beat completes the vector and the FSM stays in IDLE.
REQ-016: cfg_len changes while in ACCUM are ignored until the next vector starts.
REQ-017: Each beat with in_valid=1 adds zero-extended in_sum to acc and increments cnt.
REQ-018: The beat with cnt = len-1 pushes acc+in_sum into the FIFO, clears acc and cnt in the same cycle, and returns the FSM to IDLE.
REQ-019: Back-to-back vectors are supported: the next beat in the following cycle starts a new vector with no bubble.
REQ-020: Cycles with in_valid=0 hold all accumulator state.
REQ-021: Accumulator overflow wraps modulo 2^ACC_W (see REQ-033 for the alternative).
REQ-022: Latency: the result is registered; out_valid rises the cycle after the final beat is sampled, provided the FIFO was empty.
REQ-023: A pop occurs when out_valid=1 and out_ready=1; out_acc and out_valid stay stable while out_ready=0.
REQ-024: The FIFO occupancy FSM has states EMPTY, ONE and FULL, and results leave in order.
REQ-025: A push and a pop in the same cycle are both honoured; occupancy is unchanged, including in FULL.
REQ-026: A push while FULL without a pop discards the new result, keeps the stored entries and sets out_drop.
REQ-027: out_drop stays set until reset; clear does not affect it.
REQ-028: clear=1 zeroes acc and cnt and returns the FSM to IDLE; any in_valid beat in the same cycle is discarded.
REQ-029: clear does not affect FIFO contents or out_valid.

Reset
REQ-030: When rst=1 at a clock edge, the following are reset: FSM to IDLE, acc=0, cnt=0, length register=1, FIFO EMPTY, out_valid=0, out_acc=0, out_drop=0.
REQ-031: Reset asserted mid-vector or with results pending discards all of them; rst has priority over clear and in_valid.
REQ-032: Beats with in_valid=1 arriving in the first cycle after rst falls are accepted normally.

Configuration
REQ-033: Macro ACCUM_SAT_EN defined: the accumulator and the pushed result saturate at 2^ACC_W-1 and stay there until the vector ends.
REQ-034: Macro ACCUM_SAT_EN undefined: the accumulator wraps modulo 2^ACC_W per REQ-021, with no saturation logic synthesized.

Verification
REQ-035: cfg_len=4, out_ready=1, four consecutive beats of 0xFE01 -> one result 0x3F804, out_valid for exactly 1 cycle, 1 cycle after the 4th beat.
REQ-036: cfg_len=1, out_ready=1, continuous beats 1,2,3,...,2000 -> 2000 results equal to the inputs in order, out_drop=0.
REQ-037: cfg_len=1, out_ready=0, beats 5,6,7 -> FIFO holds 5 then 6, out_drop=1; raising out_ready pops 5 then 6, then out_valid=0.
REQ-038: cfg_len=4, beats 1,1, then clear, then beats 2,2,2,2 -> single result 8.
REQ-039: ACC_W=18, cfg_len=8, eight beats of 0xFE01 -> result 0x3F008 without ACCUM_SAT_EN and 0x3FFFF with it.
REQ-040: FIFO FULL with out_ready=1 while a final beat arrives -> the head pops and the new result is stored, occupancy stays FULL, out_drop=0.

Source files
------------

// File: rtl/mac_accum_drain.sv
// mac_accum_drain: accumulates cfg_len unsigned product beats into one
// dot-product result and drains results through a 2-entry output FIFO.
// Optional feature: define ACCUM_SAT_EN to saturate the accumulator at
// 2^ACC_W-1 instead of wrapping modulo 2^ACC_W.
module mac_accum_drain #(
  parameter int unsigned ACC_W = 32,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [17:0]      in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_drop
);

  typedef enum logic {
    V_IDLE,
    V_ACCUM
  } vec_state_t;

  typedef enum logic [1:0] {
    F_EMPTY,
    F_ONE,
    F_FULL
  } fifo_state_t;

  vec_state_t  vec_state, vec_next;
  fifo_state_t fifo_state, fifo_next;

  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] acc_sum;
  logic [LEN_W-1:0] eff_len;
  logic [LEN_W-1:0] cur_len;
  logic             last_beat;
  logic             push;
  logic             pop;

  logic [ACC_W-1:0] head_q;
  logic [ACC_W-1:0] tail_q;
  logic             drop_q;

  // A length of zero behaves as a single-beat vector.
  assign eff_len = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
  // In IDLE the incoming beat starts a vector, so its length comes from cfg_len.
  assign cur_len   = (vec_state == V_IDLE) ? eff_len : len_q;
  assign last_beat = (cnt_q == (cur_len - LEN_W'(1)));

`ifdef ACCUM_SAT_EN
  logic [ACC_W:0] acc_wide;
  assign acc_wide = {1'b0, acc_q} + {1'b0, ACC_W'(in_sum)};
  assign acc_sum  = acc_wide[ACC_W] ? '1 : acc_wide[ACC_W-1:0];
`else
  assign acc_sum = acc_q + ACC_W'(in_sum);
`endif

  // Vector FSM next state: accumulate beats, emit a push on the final beat.
  always_comb begin
    vec_next = vec_state;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    push     = 1'b0;
    if (clear) begin
      vec_next = V_IDLE;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (in_valid) begin
      if (vec_state == V_IDLE) begin
        len_d = eff_len;
      end
      if (last_beat) begin
        push     = 1'b1;
        acc_d    = '0;
        cnt_d    = '0;
        vec_next = V_IDLE;
      end else begin
        acc_d    = acc_sum;
        cnt_d    = cnt_q + LEN_W'(1);
        vec_next = V_ACCUM;
      end
    end
  end

  // Vector state, accumulator, beat counter and length register.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_state <= V_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      len_q     <= LEN_W'(1);
    end else begin
      vec_state <= vec_next;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
    end
  end

  assign out_valid = (fifo_state != F_EMPTY);
  assign pop       = out_valid && out_ready;
  assign out_acc   = head_q;
  assign out_drop  = drop_q;

  // FIFO occupancy next state; a simultaneous push and pop keeps occupancy.
  always_comb begin
    fifo_next = fifo_state;
    case (fifo_state)
      F_EMPTY: if (push) fifo_next = F_ONE;
      F_ONE: begin
        if (push && !pop)      fifo_next = F_FULL;
        else if (!push && pop) fifo_next = F_EMPTY;
      end
      F_FULL:  if (pop && !push) fifo_next = F_ONE;
      default: fifo_next = F_EMPTY;
    endcase
  end

  // FIFO storage: head drives the output, tail shifts in on pop; overflow sets drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_state <= F_EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      drop_q     <= 1'b0;
    end else begin
      fifo_state <= fifo_next;
      case (fifo_state)
        F_EMPTY: if (push) head_q <= acc_sum;
        F_ONE: begin
          if (push && pop) head_q <= acc_sum;
          else if (push)   tail_q <= acc_sum;
        end
        F_FULL: begin
          if (pop) begin
            head_q <= tail_q;
            if (push) tail_q <= acc_sum;
          end else if (push) begin
            drop_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_accum_drain.sv
// Self-checking bench for mac_accum_drain: table-driven vectors plus
// hand-written corner sequences, with a result scoreboard queue.
module tb_mac_accum_drain;

  logic        clk;
  logic        rst;
  logic [7:0]  cfg_len;
  logic        clear;
  logic        in_valid;
  logic [17:0] in_sum;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_acc;
  logic        out_drop;

  logic        in_valid18;
  logic        out_valid18;
  logic [17:0] out_acc18;
  logic        out_drop18;

  int unsigned n_vec;
  int unsigned n_bad;
  logic [31:0] sb[$];

  mac_accum_drain #(.ACC_W(32), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_len(cfg_len), .clear(clear),
    .in_valid(in_valid), .in_sum(in_sum), .out_valid(out_valid),
    .out_ready(out_ready), .out_acc(out_acc), .out_drop(out_drop)
  );

  mac_accum_drain #(.ACC_W(18), .LEN_W(8)) dut18 (
    .clk(clk), .rst(rst), .cfg_len(cfg_len), .clear(clear),
    .in_valid(in_valid18), .in_sum(in_sum), .out_valid(out_valid18),
    .out_ready(1'b1), .out_acc(out_acc18), .out_drop(out_drop18)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard: compare every accepted result against the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL sb_unexpected: got %h expected none", out_acc);
      end else begin
        check("sb_result", out_acc, sb.pop_front());
      end
    end
  end

  task automatic drive(input logic v, input logic [17:0] s, input logic [7:0] len,
                       input logic clr);
    @(posedge clk);
    #1;
    in_valid   = v;
    in_sum     = s;
    cfg_len    = len;
    clear      = clr;
    in_valid18 = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 18'd0, cfg_len, 1'b0);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 50 && sb.size() != 0; i++) idle();
    idle();
    check("sb_drained", sb.size(), 0);
  endtask

  typedef struct {
    int unsigned len;
    logic [17:0] start;
    logic [17:0] step;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int unsigned n;
    logic [17:0] v;
    logic [17:0] exp18;

    tbl[0] = '{4, 18'h0FE01, 18'd0,  32'h0003F804};
    tbl[1] = '{1, 18'd7,     18'd0,  32'd7};
    tbl[2] = '{0, 18'd9,     18'd0,  32'd9};
    tbl[3] = '{3, 18'd1,     18'd1,  32'd6};
    tbl[4] = '{2, 18'h3FFFF, 18'd0,  32'h0007FFFE};
    tbl[5] = '{5, 18'd100,   18'd10, 32'd600};

    n_vec = 0; n_bad = 0;
    rst = 1'b1; cfg_len = 8'd1; clear = 1'b0; in_valid = 1'b0; in_sum = '0;
    out_ready = 1'b1; in_valid18 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_acc",   out_acc, 32'd0);
    check("rst_out_drop",  {31'd0, out_drop}, 32'd0);
    #1 rst = 1'b0;

    // Single length-4 vector: result appears one cycle after the last beat, for one cycle.
    for (int k = 0; k < 4; k++) drive(1'b1, 18'h0FE01, 8'd4, 1'b0);
    sb.push_back(32'h0003F804);
    @(negedge clk);
    check("lat_before", {31'd0, out_valid}, 32'd0);
    idle();
    @(negedge clk);
    check("lat_valid", {31'd0, out_valid}, 32'd1);
    idle();
    @(negedge clk);
    check("lat_one_cycle", {31'd0, out_valid}, 32'd0);

    // Table vectors, back to back with no bubble.
    for (int i = 0; i < 6; i++) begin
      n = (tbl[i].len == 0) ? 1 : tbl[i].len;
      for (int k = 0; k < int'(n); k++) begin
        v = tbl[i].start + 18'(k) * tbl[i].step;
        drive(1'b1, v, 8'(tbl[i].len), 1'b0);
        if (k == int'(n) - 1) sb.push_back(tbl[i].exp);
      end
    end
    drain();

    // cfg_len changes mid-vector are ignored.
    drive(1'b1, 18'd1, 8'd3, 1'b0);
    drive(1'b1, 18'd2, 8'd1, 1'b0);
    drive(1'b1, 18'd4, 8'd1, 1'b0);
    sb.push_back(32'd7);
    drain();

    // Streaming single-beat vectors.
    for (int k = 1; k <= 2000; k++) begin
      drive(1'b1, 18'(k), 8'd1, 1'b0);
      sb.push_back(32'(k));
    end
    drain();
    check("stream_drop", {31'd0, out_drop}, 32'd0);

    // Clear aborts the vector and discards its own beat.
    drive(1'b1, 18'd1, 8'd4, 1'b0);
    drive(1'b1, 18'd1, 8'd4, 1'b0);
    drive(1'b1, 18'd50, 8'd4, 1'b1);
    for (int k = 0; k < 4; k++) drive(1'b1, 18'd2, 8'd4, 1'b0);
    sb.push_back(32'd8);
    drain();

    // Overflow while FULL: third result is dropped, head held stable.
    out_ready = 1'b0;
    drive(1'b1, 18'd5, 8'd1, 1'b0);
    drive(1'b1, 18'd6, 8'd1, 1'b0);
    drive(1'b1, 18'd7, 8'd1, 1'b0);
    sb.push_back(32'd5);
    sb.push_back(32'd6);
    idle();
    @(negedge clk);
    check("full_drop", {31'd0, out_drop}, 32'd1);
    check("full_valid", {31'd0, out_valid}, 32'd1);
    check("full_head", out_acc, 32'd5);
    idle(); idle();
    @(negedge clk);
    check("hold_head", out_acc, 32'd5);
    drive(1'b0, 18'd0, 8'd1, 1'b1);
    idle();
    @(negedge clk);
    check("drop_after_clear", {31'd0, out_drop}, 32'd1);
    check("head_after_clear", out_acc, 32'd5);
    drain();
    check("empty_after_pops", {31'd0, out_valid}, 32'd0);

    // Reset with results pending discards them and clears the drop flag.
    out_ready = 1'b0;
    drive(1'b1, 18'd40, 8'd1, 1'b0);
    drive(1'b1, 18'd41, 8'd2, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1; in_valid = 1'b0;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    check("rst2_valid", {31'd0, out_valid}, 32'd0);
    check("rst2_drop", {31'd0, out_drop}, 32'd0);

    // Beat in the first cycle after reset, then push+pop while FULL.
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b1; in_sum = 18'd10; cfg_len = 8'd1;
    sb.push_back(32'd10);
    drive(1'b1, 18'd20, 8'd1, 1'b0);
    sb.push_back(32'd20);
    drive(1'b1, 18'd30, 8'd1, 1'b0);
    out_ready = 1'b1;
    sb.push_back(32'd30);
    idle();
    out_ready = 1'b0;
    @(negedge clk);
    check("pp_full_valid", {31'd0, out_valid}, 32'd1);
    check("pp_full_head", out_acc, 32'd20);
    check("pp_full_drop", {31'd0, out_drop}, 32'd0);
    drain();
    check("pp_drop_final", {31'd0, out_drop}, 32'd0);

    // 18-bit accumulator: wraps, or saturates when the feature is built in.
`ifdef ACCUM_SAT_EN
    exp18 = 18'h3FFFF;
`else
    exp18 = 18'h3F008;
`endif
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      in_valid18 = 1'b1; in_sum = 18'h0FE01; cfg_len = 8'd8;
    end
    @(posedge clk);
    #1;
    in_valid18 = 1'b0;
    @(negedge clk);
    check("acc18_valid", {31'd0, out_valid18}, 32'd1);
    check("acc18_value", {14'd0, out_acc18}, {14'd0, exp18});
    check("acc18_drop", {31'd0, out_drop18}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
